// File: rtl/reaction_judge_pkg.sv
// Shared definitions for the 2-player reaction game: state encoding, winner
// codes, the 1 Hz tick default and the delay clamp helper.
package reaction_judge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_GO     = 2'd2,
      ST_RESULT = 2'd3
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   // Terminal count of the 1 Hz tick divider at 50 MHz; also used by the ready generator.
   localparam int TICK_MAX_1HZ = 49_999_999;

   function automatic logic [2:0] clampNum(input logic [3:0] value, input logic [3:0] limit);
      logic [3:0] w_result;
      w_result = (value > limit) ? limit : value;
      return w_result[2:0];
   endfunction

endpackage

// File: rtl/reaction_judge_btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button followed by a registered
// rising-edge detector; a held button yields exactly one pulse.
module btn_sync_edge (
   input  logic CLK,
   input  logic RST,
   input  logic i_pin,
   output logic o_press
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_press;

   // Pin to pulse takes three edges: meta, sync, then the registered edge pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_prev  <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_meta  <= i_pin;
         r_sync  <= r_meta;
         r_prev  <= r_sync;
         r_press <= r_sync & ~r_prev;
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/reaction_judge.sv
// Reaction judge: counts down a captured delay on a 1 Hz tick, raises go, then
// decides the first press (or false start / timeout) for a two-player round.
module reaction_judge
   import reaction_judge_pkg::*;
#(
   parameter int TICK_MAX  = TICK_MAX_1HZ,
   parameter int TIMEOUT_S = 5,
   parameter int NUM_MAX   = 6
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       IN_1P,
   input  logic       IN_2P,
   input  logic [3:0] num,
   input  logic       num_vld,
   output logic       go,
   output logic [1:0] winner,
   output logic       false_start,
   output logic       done,
   output logic [2:0] secs_left
);

   localparam int TICK_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
   localparam int TO_W   = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;

   state_t            r_state;
   state_t            w_nextState;
   logic [TICK_W-1:0] r_tickCnt;
   logic [TO_W-1:0]   r_timeoutCnt;
   logic [TO_W-1:0]   w_nextTimeout;
   logic [2:0]        r_secsLeft;
   logic [2:0]        w_nextSecs;
   logic [2:0]        w_loadSecs;
   logic [1:0]        r_winner;
   logic [1:0]        w_nextWinner;
   logic              r_falseStart;
   logic              w_nextFalseStart;
   logic              w_press1;
   logic              w_press2;
   logic              w_tick;
   logic              w_stateChange;

   btn_sync_edge u_btn1 (
      .CLK     (CLK),
      .RST     (RST),
      .i_pin   (IN_1P),
      .o_press (w_press1)
   );

   btn_sync_edge u_btn2 (
      .CLK     (CLK),
      .RST     (RST),
      .i_pin   (IN_2P),
      .o_press (w_press2)
   );

   assign w_tick        = (r_tickCnt == TICK_W'(TICK_MAX));
   assign w_stateChange = (w_nextState != r_state);
   assign w_loadSecs    = clampNum(num, 4'(NUM_MAX));

   // Restarting the divider on every state entry makes the first interval a full second.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_tickCnt <= '0;
      end else if (w_stateChange || w_tick) begin
         r_tickCnt <= '0;
      end else begin
         r_tickCnt <= r_tickCnt + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= ST_IDLE;
         r_secsLeft   <= 3'd0;
         r_winner     <= WIN_NONE;
         r_falseStart <= 1'b0;
         r_timeoutCnt <= '0;
      end else begin
         r_state      <= w_nextState;
         r_secsLeft   <= w_nextSecs;
         r_winner     <= w_nextWinner;
         r_falseStart <= w_nextFalseStart;
         r_timeoutCnt <= w_nextTimeout;
      end
   end

   always_comb begin
      w_nextState      = r_state;
      w_nextSecs       = r_secsLeft;
      w_nextWinner     = r_winner;
      w_nextFalseStart = r_falseStart;
      w_nextTimeout    = r_timeoutCnt;
      case (r_state)
         ST_IDLE, ST_RESULT: begin
            if (num_vld) begin
               w_nextSecs       = w_loadSecs;
               w_nextWinner     = WIN_NONE;
               w_nextFalseStart = 1'b0;
               w_nextTimeout    = '0;
               w_nextState      = (w_loadSecs == 3'd0) ? ST_GO : ST_WAIT;
            end
         end
         ST_WAIT: begin
            // An early press hands the round to the opponent.
            if (w_press1 || w_press2) begin
               w_nextFalseStart = 1'b1;
               w_nextState      = ST_RESULT;
               if (w_press1 && w_press2) begin
                  w_nextWinner = WIN_DRAW;
               end else if (w_press1) begin
                  w_nextWinner = WIN_P2;
               end else begin
                  w_nextWinner = WIN_P1;
               end
            end else if (w_tick) begin
               w_nextSecs = r_secsLeft - 3'd1;
               if (r_secsLeft == 3'd1) begin
                  w_nextTimeout = '0;
                  w_nextState   = ST_GO;
               end
            end
         end
         ST_GO: begin
            if (w_press1 || w_press2) begin
               w_nextFalseStart = 1'b0;
               w_nextState      = ST_RESULT;
               if (w_press1 && w_press2) begin
                  w_nextWinner = WIN_DRAW;
               end else if (w_press1) begin
                  w_nextWinner = WIN_P1;
               end else begin
                  w_nextWinner = WIN_P2;
               end
            end else if (w_tick) begin
               if (r_timeoutCnt == TO_W'(TIMEOUT_S - 1)) begin
                  w_nextWinner = WIN_NONE;
                  w_nextState  = ST_RESULT;
               end else begin
                  w_nextTimeout = r_timeoutCnt + 1'b1;
               end
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   assign go          = (r_state == ST_GO);
   assign done        = (r_state == ST_RESULT);
   assign winner      = r_winner;
   assign false_start = r_falseStart;
   assign secs_left   = r_secsLeft;

endmodule

// File: tb/tb_reaction_judge.sv
// Directed bench for reaction_judge with a 10-cycle tick; every expectation
// below is hand-derived from edge counts relative to the num_vld strobe.
module tb_reaction_judge;

   logic       CLK = 1'b0;
   logic       RST;
   logic       IN_1P;
   logic       IN_2P;
   logic [3:0] num;
   logic       num_vld;
   logic       go;
   logic [1:0] winner;
   logic       false_start;
   logic       done;
   logic [2:0] secs_left;

   int testsRun    = 0;
   int testsFailed = 0;

   always #5 CLK = ~CLK;

   reaction_judge #(
      .TICK_MAX  (9),
      .TIMEOUT_S (5),
      .NUM_MAX   (6)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .IN_1P       (IN_1P),
      .IN_2P       (IN_2P),
      .num         (num),
      .num_vld     (num_vld),
      .go          (go),
      .winner      (winner),
      .false_start (false_start),
      .done        (done),
      .secs_left   (secs_left)
   );

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // One-cycle num_vld strobe; returns 1 ns after the edge that samples it.
   task automatic applyStimulus(input logic [3:0] value);
      num     = value;
      num_vld = 1'b1;
      step(1);
      num_vld = 1'b0;
   endtask

   task automatic checkField(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag, input logic eGo, input logic eDone,
                              input logic [1:0] eWin, input logic eFs);
      checkField({tag, ".go"}, {7'd0, go}, {7'd0, eGo});
      checkField({tag, ".done"}, {7'd0, done}, {7'd0, eDone});
      checkField({tag, ".winner"}, {6'd0, winner}, {6'd0, eWin});
      checkField({tag, ".false_start"}, {7'd0, false_start}, {7'd0, eFs});
   endtask

   task automatic checkSecs(input string tag, input logic [2:0] eSecs);
      checkField({tag, ".secs_left"}, {5'd0, secs_left}, {5'd0, eSecs});
   endtask

   initial begin
      RST     = 1'b1;
      IN_1P   = 1'b0;
      IN_2P   = 1'b0;
      num     = 4'd0;
      num_vld = 1'b0;
      step(3);
      RST = 1'b0;
      checkOutput("reset", 1'b0, 1'b0, 2'b00, 1'b0);
      checkSecs("reset", 3'd0);

      // Countdown from 3 then timeout: go at s+30, result at s+80.
      applyStimulus(4'd3);
      checkOutput("t1.load", 1'b0, 1'b0, 2'b00, 1'b0);
      checkSecs("t1.load", 3'd3);
      step(9);
      checkSecs("t1.s9", 3'd3);
      step(1);
      checkSecs("t1.s10", 3'd2);
      step(10);
      checkSecs("t1.s20", 3'd1);
      step(9);
      checkOutput("t1.s29", 1'b0, 1'b0, 2'b00, 1'b0);
      step(1);
      checkOutput("t1.s30", 1'b1, 1'b0, 2'b00, 1'b0);
      checkSecs("t1.s30", 3'd0);
      step(49);
      checkOutput("t1.s79", 1'b1, 1'b0, 2'b00, 1'b0);
      step(1);
      checkOutput("t1.timeout", 1'b0, 1'b1, 2'b00, 1'b0);

      // P1 presses 12 CLK after go (s+32); result four edges later.
      applyStimulus(4'd2);
      checkSecs("t2.load", 3'd2);
      step(20);
      checkOutput("t2.go", 1'b1, 1'b0, 2'b00, 1'b0);
      step(12);
      IN_1P = 1'b1;
      step(3);
      checkOutput("t2.pin3", 1'b1, 1'b0, 2'b00, 1'b0);
      step(1);
      checkOutput("t2.pin4", 1'b0, 1'b1, 2'b01, 1'b0);
      IN_1P = 1'b0;
      IN_2P = 1'b1;
      step(6);
      checkOutput("t2.late2p", 1'b0, 1'b1, 2'b01, 1'b0);
      IN_2P = 1'b0;
      step(4);

      // P2 false start in the second second of WAIT: pulse s+15, result s+16.
      applyStimulus(4'd4);
      step(12);
      IN_2P = 1'b1;
      step(2);
      IN_2P = 1'b0;
      step(1);
      checkOutput("t3.pulse", 1'b0, 1'b0, 2'b00, 1'b0);
      step(1);
      checkOutput("t3.false", 1'b0, 1'b1, 2'b01, 1'b1);
      step(10);
      checkOutput("t3.hold", 1'b0, 1'b1, 2'b01, 1'b1);

      // Simultaneous press after go, then during WAIT.
      applyStimulus(4'd1);
      step(10);
      checkOutput("t4.go", 1'b1, 1'b0, 2'b00, 1'b0);
      step(2);
      IN_1P = 1'b1;
      IN_2P = 1'b1;
      step(4);
      checkOutput("t4.draw", 1'b0, 1'b1, 2'b11, 1'b0);
      IN_1P = 1'b0;
      IN_2P = 1'b0;
      step(4);
      applyStimulus(4'd1);
      checkOutput("t4.reload", 1'b0, 1'b0, 2'b00, 1'b0);
      step(2);
      IN_1P = 1'b1;
      IN_2P = 1'b1;
      step(4);
      checkOutput("t4.falsedraw", 1'b0, 1'b1, 2'b11, 1'b1);
      IN_1P = 1'b0;
      IN_2P = 1'b0;
      step(4);

      // num=0 goes straight to GO; num=9 clamps to 6.
      applyStimulus(4'd0);
      checkOutput("t5.zero", 1'b1, 1'b0, 2'b00, 1'b0);
      checkSecs("t5.zero", 3'd0);
      step(50);
      checkOutput("t5.zerotimeout", 1'b0, 1'b1, 2'b00, 1'b0);
      applyStimulus(4'd9);
      checkSecs("t5.clamp", 3'd6);
      step(59);
      checkOutput("t5.s59", 1'b0, 1'b0, 2'b00, 1'b0);
      checkSecs("t5.s59", 3'd1);
      step(1);
      checkOutput("t5.s60", 1'b1, 1'b0, 2'b00, 1'b0);

      // Strobe during GO is ignored; timeout still lands at s+110.
      applyStimulus(4'd2);
      checkOutput("t6.vldgo", 1'b1, 1'b0, 2'b00, 1'b0);
      checkSecs("t6.vldgo", 3'd0);
      step(49);
      checkOutput("t6.timeout", 1'b0, 1'b1, 2'b00, 1'b0);

      // Strobe in RESULT clears the result, then reset aborts mid-WAIT.
      applyStimulus(4'd3);
      checkOutput("t6.restart", 1'b0, 1'b0, 2'b00, 1'b0);
      checkSecs("t6.restart", 3'd3);
      step(12);
      checkSecs("t6.midwait", 3'd2);
      RST = 1'b1;
      step(1);
      RST = 1'b0;
      checkOutput("t6.rst", 1'b0, 1'b0, 2'b00, 1'b0);
      checkSecs("t6.rst", 3'd0);
      step(40);
      checkOutput("t6.idle", 1'b0, 1'b0, 2'b00, 1'b0);
      checkSecs("t6.idle", 3'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/reaction_judge.md
Name: reaction_judge

Overview:
- Consumer end of the 2-player "ready" number interface.
- Accepts a captured delay value num (0..6 s), counts it down on an internal 1 Hz tick, then asserts GO.
- Arbitrates the first player button press after GO and flags false starts made before GO.
- Sits between the ready/number generator and the score/display logic of the 2P game.

Parameters:
- TICK_MAX, 49_999_999, tick counter terminal value; one tick per TICK_MAX+1 CLK cycles (1 s at 50 MHz). Bench overrides to a small value.
- TIMEOUT_S, 5, seconds in GO with no press before the round ends with no winner.
- NUM_MAX, 6, largest legal num; larger values are clamped to NUM_MAX.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous, active-high reset
- IN_1P  input  1  player-1 button, asynchronous, active-high
- IN_2P  input  1  player-2 button, asynchronous, active-high
- num  input  4  delay in seconds from the ready generator
- num_vld  input  1  one-cycle strobe: num is valid this cycle
- go  output  1  high while in GO state
- winner  output  2  00 none, 01 P1, 10 P2, 11 draw; valid while done=1
- false_start  output  1  result was decided by an early press; valid while done=1
- done  output  1  high in RESULT state
- secs_left  output  3  remaining countdown seconds, for display

Behaviour:
- Reset (RST=1 at a CLK edge): state IDLE; go=0, winner=00, false_start=0, done=0, secs_left=0; tick counter, synchronizer flops and edge registers cleared.
- Button path: per input, 2-flop synchronizer, then rising-edge detect (sync & ~prev).
  - press_1 / press_2 are one-cycle pulses.
  - Latency: 3 CLK from a pin rise to the press pulse.
  - Held buttons produce no further pulses.
- Tick: counter counts 0..TICK_MAX; tick=1 in the cycle the count equals TICK_MAX, then wraps to 0. Counter clears on every state entry, so the first interval after entry is a full second.
- States: IDLE, WAIT, GO, RESULT.
- IDLE:
  - Outputs low.
  - num_vld=1 loads secs_left=min(num,NUM_MAX) and moves to WAIT, or straight to GO if that value is 0.
  - Presses are ignored.
- WAIT:
  - On tick, secs_left decrements.
  - On the tick where secs_left==1: secs_left becomes 0 and the state moves to GO next cycle.
- False start in WAIT, with priority over tick in the same cycle:
  - press_1 only: winner=10, false_start=1.
  - press_2 only: winner=01, false_start=1.
  - Both pulses in the same cycle: winner=11, false_start=1.
  - Next state is RESULT.
- GO:
  - go=1. A timeout counter counts ticks.
  - First press pulse wins: press_1 gives 01, press_2 gives 10, both in the same cycle gives 11. false_start=0; next state RESULT.
  - After TIMEOUT_S ticks with no press: winner=00, next state RESULT.
  - A press in the same cycle as the timeout tick wins over the timeout.
- RESULT:
  - done=1, go=0; winner and false_start hold.
  - Presses are ignored.
  - num_vld=1 clears winner and false_start and starts a new round exactly as from IDLE, same cycle rules.
- num_vld in WAIT or GO is ignored (no restart mid-round).
- Outputs are registered. A press pulse at edge t gives winner/done at edge t+1. go falls in the same cycle done rises.
- Reset mid-round returns to IDLE and aborts the round with no result.

Decomposition:
- Shared game package holds:
  - state encoding (IDLE/WAIT/GO/RESULT);
  - winner codes (WIN_NONE=00, WIN_P1=01, WIN_P2=10, WIN_DRAW=11);
  - the 1 Hz TICK_MAX default shared with the ready generator.
- One sub-module, btn_sync_edge: 2-flop synchronizer plus rising-edge pulse, instantiated once per player.

Test Plan (TICK_MAX=9, i.e. one tick per 10 CLK):
1. num=3 with num_vld; no presses -> go rises 30 CLK (+1) after the strobe, secs_left steps 3,2,1,0; after 5 ticks in GO, done=1, winner=00, false_start=0.
2. num=2; IN_1P rises 12 CLK after go -> winner=01, false_start=0, done=1 four CLK after the pin rise; IN_2P pressed afterwards leaves winner unchanged.
3. num=4; IN_2P pulses during the second second of WAIT -> winner=01, false_start=1, go never asserted.
4. num=1; IN_1P and IN_2P rise on the same CLK edge after go -> winner=11, false_start=0. The same simultaneous press during WAIT -> winner=11, false_start=1.
5. num=0 -> go asserted in the cycle after the strobe. num=9 -> clamped, secs_left=6, go after 60 CLK.
6. RST asserted mid-WAIT -> all outputs 0 on the next edge, state IDLE. num_vld during GO -> ignored. num_vld in RESULT -> outputs cleared, new countdown starts.
